// File: rtl/framebuffer_scanout.sv
// Display raster timing generator and framebuffer reader.
// Owns double-buffer selection, flipped on the first blank line.
module framebuffer_scanout #(
  parameter int DISPLAY_WIDTH         = 100,
  parameter int DISPLAY_HEIGHT        = 100,
  parameter int H_FRONT               = 2,
  parameter int H_SYNC                = 4,
  parameter int H_BACK                = 4,
  parameter int V_FRONT               = 1,
  parameter int V_SYNC                = 2,
  parameter int V_BACK                = 2,
  parameter int FRAMEBUFFER_DATA_BITS = 16,
  parameter int FRAMEBUFFER_SIZE      = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter int FRAMEBUFFER_ADDR_BITS = $clog2(FRAMEBUFFER_SIZE),
  parameter int RD_LATENCY            = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             fb_rd_en,
  output logic [FRAMEBUFFER_ADDR_BITS:0]   fb_rd_addr,
  input  logic [FRAMEBUFFER_DATA_BITS-1:0] fb_rd_data,
  output logic                             hsync,
  output logic                             vsync,
  output logic                             de,
  output logic [FRAMEBUFFER_DATA_BITS-1:0] pixel_data,
  output logic                             frame_start,
  output logic                             buffer_sel,
  input  logic                             swap_req,
  output logic                             swap_ack
);

  localparam int H_TOTAL = DISPLAY_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = DISPLAY_HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = FRAMEBUFFER_ADDR_BITS;
  localparam int L  = RD_LATENCY;

  localparam logic [HW-1:0] H_ACT  = HW'(DISPLAY_WIDTH);
  localparam logic [HW-1:0] H_SS   = HW'(DISPLAY_WIDTH + H_FRONT);
  localparam logic [HW-1:0] H_SE   = HW'(DISPLAY_WIDTH + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(DISPLAY_HEIGHT);
  localparam logic [VW-1:0] V_LA   = VW'(DISPLAY_HEIGHT - 1);
  localparam logic [VW-1:0] V_SS   = VW'(DISPLAY_HEIGHT + V_FRONT);
  localparam logic [VW-1:0] V_SE   = VW'(DISPLAY_HEIGHT + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(DISPLAY_WIDTH);

  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic [AW-1:0] row_base;
  logic          active;
  logic          h_wrap;
  logic          hs_raw;
  logic          vs_raw;
  logic          fs_raw;
  logic          swap_point;

  logic          de0;
  logic          hs0;
  logic          vs0;
  logic          fs0;
  logic [L-1:0]  de_sr;
  logic [L-1:0]  hs_sr;
  logic [L-1:0]  vs_sr;
  logic [L-1:0]  fs_sr;

  assign active     = (h_count < H_ACT) && (v_count < V_ACT);
  assign h_wrap     = (h_count == H_LAST);
  assign hs_raw     = !((h_count >= H_SS) && (h_count < H_SE));
  assign vs_raw     = !((v_count >= V_SS) && (v_count < V_SE));
  assign fs_raw     = (h_count == '0) && (v_count == '0);
  assign swap_point = (h_count == '0) && (v_count == V_ACT);

  // Raster counters and the row-base accumulator replacing x+W*y.
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_count  <= '0;
      v_count  <= '0;
      row_base <= '0;
    end else if (h_wrap) begin
      h_count <= '0;
      if (v_count == V_LAST) begin
        v_count  <= '0;
        row_base <= '0;
      end else begin
        v_count <= v_count + VW'(1);
        if (v_count < V_LA)
          row_base <= row_base + ROW_STEP;
      end
    end else begin
      h_count <= h_count + HW'(1);
    end
  end

  // Read stage: strobe and address, plus timing flags that will ride the delay line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fb_rd_en   <= 1'b0;
      fb_rd_addr <= '0;
      de0        <= 1'b0;
      hs0        <= 1'b1;
      vs0        <= 1'b1;
      fs0        <= 1'b0;
    end else begin
      fb_rd_en <= active;
      if (active)
        fb_rd_addr <= {buffer_sel, row_base + AW'(h_count)};
      de0 <= active;
      hs0 <= hs_raw;
      vs0 <= vs_raw;
      fs0 <= fs_raw;
    end
  end

  // Delay timing by the read latency so it lines up with returned data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      de_sr <= '0;
      hs_sr <= '1;
      vs_sr <= '1;
      fs_sr <= '0;
    end else begin
      de_sr[0] <= de0;
      hs_sr[0] <= hs0;
      vs_sr[0] <= vs0;
      fs_sr[0] <= fs0;
      for (int i = 1; i < L; i++) begin
        de_sr[i] <= de_sr[i-1];
        hs_sr[i] <= hs_sr[i-1];
        vs_sr[i] <= vs_sr[i-1];
        fs_sr[i] <= fs_sr[i-1];
      end
    end
  end

  // Buffer flip, sampled once per frame at the start of vertical blank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buffer_sel <= 1'b0;
      swap_ack   <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      if (swap_point && swap_req) begin
        buffer_sel <= ~buffer_sel;
        swap_ack   <= 1'b1;
      end
    end
  end

  assign de          = de_sr[L-1];
  assign hsync       = hs_sr[L-1];
  assign vsync       = vs_sr[L-1];
  assign frame_start = fs_sr[L-1];
  assign pixel_data  = de ? fb_rd_data : '0;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout on a 4x3 raster.
// Two instances: read latency 1 and read latency 3.
module tb_framebuffer_scanout;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int HT = 8;
  localparam int VT = 6;
  localparam int FR = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        swap_req;

  logic        fb_rd_en;
  logic [4:0]  fb_rd_addr;
  logic [15:0] fb_rd_data;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [15:0] pixel_data;
  logic        frame_start;
  logic        buffer_sel;
  logic        swap_ack;

  logic        fb_rd_en3;
  logic [4:0]  fb_rd_addr3;
  logic [15:0] fb_rd_data3;
  logic        hsync3;
  logic        vsync3;
  logic        de3;
  logic [15:0] pixel_data3;
  logic        frame_start3;
  logic        buffer_sel3;
  logic        swap_ack3;

  framebuffer_scanout #(
    .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H),
    .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .FRAMEBUFFER_DATA_BITS(16), .RD_LATENCY(1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr),
    .fb_rd_data(fb_rd_data),
    .hsync(hsync), .vsync(vsync), .de(de),
    .pixel_data(pixel_data), .frame_start(frame_start),
    .buffer_sel(buffer_sel), .swap_req(swap_req),
    .swap_ack(swap_ack)
  );

  framebuffer_scanout #(
    .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H),
    .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .FRAMEBUFFER_DATA_BITS(16), .RD_LATENCY(3)
  ) dut3 (
    .clk(clk), .rst(rst),
    .fb_rd_en(fb_rd_en3), .fb_rd_addr(fb_rd_addr3),
    .fb_rd_data(fb_rd_data3),
    .hsync(hsync3), .vsync(vsync3), .de(de3),
    .pixel_data(pixel_data3), .frame_start(frame_start3),
    .buffer_sel(buffer_sel3), .swap_req(swap_req),
    .swap_ack(swap_ack3)
  );

  // Memories returning data = address after the read latency.
  logic [4:0] p1;
  logic [4:0] q [3];
  always @(posedge clk) begin
    p1   <= fb_rd_addr;
    q[0] <= fb_rd_addr3;
    q[1] <= q[0];
    q[2] <= q[1];
  end
  assign fb_rd_data  = {11'd0, p1};
  assign fb_rd_data3 = {11'd0, q[2]};

  int   checks = 0;
  int   errors = 0;
  int   t;
  logic exp_buf, exp_buf_n;
  logic exp_ack, exp_ack_n;
  int   exp_addr;
  int   de_cnt, hs_low, vs_low, fs_cnt;
  logic prev_en, prev_sel;
  logic did_reset;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0d got %0h want %0h", tag, t, got, want);
    end
  endtask

  // Expected raster flags for counter cycle u (u<0 means reset values).
  function automatic void tim(input int u, output logic d,
                              output logic hs, output logic vs,
                              output logic fs, output int idx);
    int h, v;
    d = 1'b0; hs = 1'b1; vs = 1'b1; fs = 1'b0; idx = 0;
    if (u >= 0) begin
      h   = u % HT;
      v   = (u / HT) % VT;
      d   = (h < W) && (v < H);
      hs  = !(h >= 5 && h < 7);
      vs  = !(v == 4);
      fs  = (h == 0) && (v == 0);
      idx = h + W * v;
    end
  endfunction

  task automatic sample();
    logic d, hs, vs, fs, d3, hs3, vs3, fs3, re, x1, x2, x3;
    int   idx, idx3, ridx, b;
    b = exp_buf ? 16 : 0;
    tim(t - 2, d, hs, vs, fs, idx);
    chk("de", de, d);
    chk("hsync", hsync, hs);
    chk("vsync", vsync, vs);
    chk("frame_start", frame_start, fs);
    chk("pixel", pixel_data, d ? b + idx : 0);
    tim(t - 4, d3, hs3, vs3, fs3, idx3);
    chk("de3", de3, d3);
    chk("hsync3", hsync3, hs3);
    chk("frame_start3", frame_start3, fs3);
    chk("pixel3", pixel_data3, d3 ? b + idx3 : 0);
    tim(t - 1, re, x1, x2, x3, ridx);
    if (re) exp_addr = b + ridx;
    chk("rd_en", fb_rd_en, re);
    chk("rd_addr", fb_rd_addr, exp_addr);
    chk("rd_addr3", fb_rd_addr3, exp_addr);
    chk("buffer_sel", buffer_sel, exp_buf);
    chk("buffer_sel3", buffer_sel3, exp_buf);
    chk("swap_ack", swap_ack, exp_ack);
    if (fb_rd_en && prev_en) chk("sel_stable", buffer_sel, prev_sel);
    prev_en  = fb_rd_en;
    prev_sel = buffer_sel;
    if (t - 2 >= 0) begin
      de_cnt += int'(de);
      hs_low += int'(!hsync);
      vs_low += int'(!vsync);
      fs_cnt += int'(frame_start);
      if ((t - 2) % HT == HT - 1) begin
        chk("hsync_len", hs_low, 2);
        hs_low = 0;
      end
      if ((t - 2) % FR == FR - 1) begin
        chk("de_per_frame", de_cnt, 12);
        chk("vsync_len", vs_low, 8);
        chk("fs_per_frame", fs_cnt, 1);
        de_cnt = 0; vs_low = 0; fs_cnt = 0;
      end
    end
  endtask

  task automatic model_reset();
    t = 0; exp_buf = 1'b0; exp_ack = 1'b0; exp_addr = 0;
    de_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0;
    prev_en = 1'b0; prev_sel = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    swap_req = 1'b0;
    did_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    for (int n = 0; n < 420; n++) begin
      sample();
      rst = did_reset || (t != 250);
      if (!did_reset)
        swap_req = (t >= 68 && t <= 72) || (t >= 121 && t <= 168) ||
                   (t == 216);
      else
        swap_req = 1'b0;
      exp_ack_n = rst && (t % FR == 24) && swap_req;
      exp_buf_n = exp_ack_n ? ~exp_buf : exp_buf;
      @(posedge clk);
      #1;
      if (!rst) begin
        did_reset = 1'b1;
        model_reset();
      end else begin
        t++;
        exp_buf = exp_buf_n;
        exp_ack = exp_ack_n;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
